// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the sum byte UART transmitter.
// Holds the FSM state enum, line levels and the default bit period.
package sum_uart_pkg;

    // PARITY stays in the enum in every build so state encodings are stable.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // 50 MHz system clock / 115200 baud.
    localparam int DEF_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and wraps.
// Ports: clk, rst (async, active-high), clear (zero the count),
// enable (count this cycle), tick (pulse while count is on its last value).
module uart_baud_tick
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_period
            $error("uart_baud_tick: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/sum_uart_tx.sv
// UART transmitter for the adder sum byte: 8N1, LSB first, idle high.
// Ports: clk, rst (async, active-high), in_data/in_valid/in_ready byte
// handshake, tx (registered serial line), busy (frame in progress).
// Build option: define SUM_UART_PARITY_EN to append an even-parity bit.
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] sh_next;
    logic [IDX_W-1:0]  bit_idx;
    logic              tx_q;
    logic              accept;
    logic              tick;
`ifdef SUM_UART_PARITY_EN
    logic              par_q;
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid & in_ready;
    assign sh_next  = shreg >> 1;
    assign tx       = tx_q;

    // Counter restarts on accept so the start bit is a full period.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (busy),
        .tick   (tick)
    );

    // tx_q is loaded with the level of the state being entered, so the
    // line changes on the same edge as the state and never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            tx_q    <= LINE_IDLE;
`ifdef SUM_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx_q <= LINE_IDLE;
                    if (accept) begin
                        shreg   <= in_data;
                        bit_idx <= '0;
                        tx_q    <= START_LVL;
                        state   <= START;
`ifdef SUM_UART_PARITY_EN
                        // Latched now because the shift register is
                        // consumed while the data bits go out.
                        par_q   <= ^in_data;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        tx_q  <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= sh_next;
                        if (bit_idx == LAST_IDX) begin
`ifdef SUM_UART_PARITY_EN
                            tx_q  <= par_q;
                            state <= PARITY;
`else
                            tx_q  <= STOP_LVL;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx_q    <= sh_next[0];
                        end
                    end
                end
`ifdef SUM_UART_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx_q  <= STOP_LVL;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        tx_q  <= LINE_IDLE;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_q  <= LINE_IDLE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
